// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: FSM state encodings, the
// register-number width and the source/destination match helper.
package pipeline_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } ctrl_state_e;

    // True when a valid ID source operand names the given destination register.
    function automatic logic srcMatch(
        input logic             useSrc1,
        input logic [REG_W-1:0] src1,
        input logic             twoSrc,
        input logic [REG_W-1:0] src2,
        input logic [REG_W-1:0] dest
    );
        return (useSrc1 && (src1 == dest)) || (twoSrc && (src2 == dest));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detector.sv
// Combinational RAW hazard detection for the instruction in ID. With forwarding
// only a load-use needs a stall; without it any pending write in EX/MEM does.
module hazard_detector
    import pipeline_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_two_src_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             ex_wb_en_i,
    input  logic             mem_wb_en_i,
    input  logic             ex_mem_rd_i,
    output logic             hazard_o
);

    logic exMatch;
    logic memMatch;

    assign exMatch  = srcMatch(id_use_src1_i, id_src1_i, id_two_src_i, id_src2_i, ex_dest_i);
    assign memMatch = srcMatch(id_use_src1_i, id_src1_i, id_two_src_i, id_src2_i, mem_dest_i);

    always_comb begin
        hazard_o = 1'b0;
        if (FWD_EN) begin
            hazard_o = ex_mem_rd_i && ex_wb_en_i && exMatch;
        end else begin
            hazard_o = (ex_wb_en_i && exMatch) || (mem_wb_en_i && memMatch);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: freezes for multi-cycle SRAM accesses, flushes
// on taken branches, bubbles on RAW hazards and counts stalled cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_CYCLES = 4,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_two_src_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             ex_wb_en_i,
    input  logic             mem_wb_en_i,
    input  logic             ex_mem_rd_i,
    input  logic             branch_taken_i,
    input  logic             mem_access_i,
    output logic             pc_ld_o,
    output logic             ifid_ld_o,
    output logic             idex_ld_o,
    output logic             exmem_ld_o,
    output logic             memwb_ld_o,
    output logic             ifid_clr_o,
    output logic             idex_clr_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam bit MEM_MULTI = (MEM_CYCLES > 1);
    localparam bit MEM_LONG  = (MEM_CYCLES > 2);
    localparam bit MEM_TWO   = (MEM_CYCLES == 2);
    localparam int WAIT_W    = (MEM_CYCLES > 3) ? $clog2(MEM_CYCLES - 2) : 1;
    localparam int WAIT_LOAD = (MEM_CYCLES > 2) ? int'(MEM_CYCLES) - 3 : 0;

    ctrl_state_e       state_q;
    logic [WAIT_W-1:0] waitCnt_q;
    logic [CNT_W-1:0]  stallCnt_q;
    logic [CNT_W-1:0]  stallCnt_d;
    logic              hazard;
    logic              frozen;

    hazard_detector #(
        .FWD_EN(FWD_EN)
    ) u_hazard (
        .id_src1_i     (id_src1_i),
        .id_src2_i     (id_src2_i),
        .id_use_src1_i (id_use_src1_i),
        .id_two_src_i  (id_two_src_i),
        .ex_dest_i     (ex_dest_i),
        .mem_dest_i    (mem_dest_i),
        .ex_wb_en_i    (ex_wb_en_i),
        .mem_wb_en_i   (mem_wb_en_i),
        .ex_mem_rd_i   (ex_mem_rd_i),
        .hazard_o      (hazard)
    );

    // RELEASE ignores mem_access so the held instruction can leave MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_access_i && MEM_LONG) begin
                        state_q   <= WAIT;
                        waitCnt_q <= WAIT_W'(WAIT_LOAD);
                    end else if (mem_access_i && MEM_TWO) begin
                        state_q <= RELEASE;
                    end
                end
                WAIT: begin
                    if (waitCnt_q == '0) begin
                        state_q <= RELEASE;
                    end else begin
                        waitCnt_q <= waitCnt_q - 1'b1;
                    end
                end
                RELEASE: state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign frozen = ((state_q == RUN) && mem_access_i && MEM_MULTI) || (state_q == WAIT);

    always_comb begin
        pc_ld_o    = 1'b0;
        ifid_ld_o  = 1'b0;
        idex_ld_o  = 1'b0;
        exmem_ld_o = 1'b0;
        memwb_ld_o = 1'b0;
        ifid_clr_o = 1'b0;
        idex_clr_o = 1'b0;
        if (!rst && !frozen) begin
            idex_ld_o  = 1'b1;
            exmem_ld_o = 1'b1;
            memwb_ld_o = 1'b1;
            // A branch flushes ID anyway, so it overrides any hazard bubble.
            if (branch_taken_i) begin
                pc_ld_o    = 1'b1;
                ifid_ld_o  = 1'b1;
                ifid_clr_o = 1'b1;
                idex_clr_o = 1'b1;
            end else if (hazard) begin
                idex_clr_o = 1'b1;
            end else begin
                pc_ld_o   = 1'b1;
                ifid_ld_o = 1'b1;
            end
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (!pc_ld_o && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: three instances (4-cycle/forwarding,
// 2-cycle/no forwarding, 1-cycle with a 2-bit counter) share one stimulus.
module tb_pipeline_ctrl;

    localparam logic [6:0] CTL_OFF    = 7'b00000_00;
    localparam logic [6:0] CTL_NORMAL = 7'b11111_00;
    localparam logic [6:0] CTL_HAZARD = 7'b00111_01;
    localparam logic [6:0] CTL_BRANCH = 7'b11111_11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] idSrc1 = '0, idSrc2 = '0, exDest = '0, memDest = '0;
    logic       idUseSrc1 = 1'b0, idTwoSrc = 1'b0, exWbEn = 1'b0, memWbEn = 1'b0;
    logic       exMemRd = 1'b0, branchTaken = 1'b0, memAccess = 1'b0;

    logic [6:0]  ctlA, ctlB, ctlC;
    logic [15:0] cntA, cntB;
    logic [1:0]  cntC;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_CYCLES(4), .FWD_EN(1'b1), .CNT_W(16)) dutA (
        .clk(clk), .rst(rst),
        .id_src1_i(idSrc1), .id_src2_i(idSrc2), .id_use_src1_i(idUseSrc1), .id_two_src_i(idTwoSrc),
        .ex_dest_i(exDest), .mem_dest_i(memDest), .ex_wb_en_i(exWbEn), .mem_wb_en_i(memWbEn),
        .ex_mem_rd_i(exMemRd), .branch_taken_i(branchTaken), .mem_access_i(memAccess),
        .pc_ld_o(ctlA[6]), .ifid_ld_o(ctlA[5]), .idex_ld_o(ctlA[4]), .exmem_ld_o(ctlA[3]),
        .memwb_ld_o(ctlA[2]), .ifid_clr_o(ctlA[1]), .idex_clr_o(ctlA[0]), .stall_cnt_o(cntA)
    );

    pipeline_ctrl #(.MEM_CYCLES(2), .FWD_EN(1'b0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst),
        .id_src1_i(idSrc1), .id_src2_i(idSrc2), .id_use_src1_i(idUseSrc1), .id_two_src_i(idTwoSrc),
        .ex_dest_i(exDest), .mem_dest_i(memDest), .ex_wb_en_i(exWbEn), .mem_wb_en_i(memWbEn),
        .ex_mem_rd_i(exMemRd), .branch_taken_i(branchTaken), .mem_access_i(memAccess),
        .pc_ld_o(ctlB[6]), .ifid_ld_o(ctlB[5]), .idex_ld_o(ctlB[4]), .exmem_ld_o(ctlB[3]),
        .memwb_ld_o(ctlB[2]), .ifid_clr_o(ctlB[1]), .idex_clr_o(ctlB[0]), .stall_cnt_o(cntB)
    );

    pipeline_ctrl #(.MEM_CYCLES(1), .FWD_EN(1'b1), .CNT_W(2)) dutC (
        .clk(clk), .rst(rst),
        .id_src1_i(idSrc1), .id_src2_i(idSrc2), .id_use_src1_i(idUseSrc1), .id_two_src_i(idTwoSrc),
        .ex_dest_i(exDest), .mem_dest_i(memDest), .ex_wb_en_i(exWbEn), .mem_wb_en_i(memWbEn),
        .ex_mem_rd_i(exMemRd), .branch_taken_i(branchTaken), .mem_access_i(memAccess),
        .pc_ld_o(ctlC[6]), .ifid_ld_o(ctlC[5]), .idex_ld_o(ctlC[4]), .exmem_ld_o(ctlC[3]),
        .memwb_ld_o(ctlC[2]), .ifid_clr_o(ctlC[1]), .idex_clr_o(ctlC[0]), .stall_cnt_o(cntC)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for the falling edge, drives a full input vector, then settles.
    task automatic applyStimulus(
        input logic br, input logic mem, input logic rd, input logic exWb, input logic [3:0] exD,
        input logic memWb, input logic [3:0] memD, input logic use1, input logic [3:0] s1,
        input logic two, input logic [3:0] s2
    );
        @(negedge clk);
        branchTaken = br;  memAccess = mem;  exMemRd = rd;
        exWbEn = exWb;     exDest = exD;     memWbEn = memWb;  memDest = memD;
        idUseSrc1 = use1;  idSrc1 = s1;      idTwoSrc = two;   idSrc2 = s2;
        #1;
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        checkOutput("reset_ctlA", 16'(ctlA), 16'(CTL_OFF));
        checkOutput("reset_cntA", cntA, 16'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_ctlA", 16'(ctlA), 16'(CTL_NORMAL));
        checkOutput("idle_ctlB", 16'(ctlB), 16'(CTL_NORMAL));
        checkOutput("idle_cntA", cntA, 16'd0);

        // Load-use on r5: stalls both forwarding and non-forwarding variants.
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("loaduse_ctlA", 16'(ctlA), 16'(CTL_HAZARD));
        checkOutput("loaduse_ctlB", 16'(ctlB), 16'(CTL_HAZARD));
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        checkOutput("loaduse_done_ctlA", 16'(ctlA), 16'(CTL_NORMAL));
        checkOutput("loaduse_cntA", cntA, 16'd1);
        checkOutput("loaduse_cntB", cntB, 16'd1);

        // Non-load ALU dependency: forwarding hides it, no-forwarding stalls.
        applyStimulus(0, 0, 0, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("alu_dep_ctlA", 16'(ctlA), 16'(CTL_NORMAL));
        checkOutput("alu_dep_ctlB", 16'(ctlB), 16'(CTL_HAZARD));

        // MEM-stage dependency through src2.
        applyStimulus(0, 0, 0, 0, 4'd0, 1, 4'd3, 0, 4'd0, 1, 4'd3);
        checkOutput("memdep_ctlB", 16'(ctlB), 16'(CTL_HAZARD));
        checkOutput("memdep_ctlA", 16'(ctlA), 16'(CTL_NORMAL));
        applyStimulus(0, 0, 0, 0, 4'd0, 1, 4'd3, 0, 4'd0, 0, 4'd3);
        checkOutput("memdep_nosrc2_ctlB", 16'(ctlB), 16'(CTL_NORMAL));
        checkOutput("memdep_cntB", cntB, 16'd3);

        // Branch together with a load-use hazard resolves as a branch.
        applyStimulus(1, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("br_hazard_ctlA", 16'(ctlA), 16'(CTL_BRANCH));
        checkOutput("br_hazard_ctlB", 16'(ctlB), 16'(CTL_BRANCH));

        // Memory op held with branch+hazard: freeze wins until RELEASE.
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k0_ctlA", 16'(ctlA), 16'(CTL_OFF));
        checkOutput("mem_k0_ctlB", 16'(ctlB), 16'(CTL_OFF));
        checkOutput("mem_k0_ctlC", 16'(ctlC), 16'(CTL_BRANCH));
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k1_ctlA", 16'(ctlA), 16'(CTL_OFF));
        checkOutput("mem_k1_ctlB", 16'(ctlB), 16'(CTL_BRANCH));
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k2_ctlA", 16'(ctlA), 16'(CTL_OFF));
        checkOutput("mem_k2_ctlB", 16'(ctlB), 16'(CTL_OFF));
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k3_release_ctlA", 16'(ctlA), 16'(CTL_BRANCH));
        checkOutput("mem_k3_cntA", cntA, 16'd4);
        checkOutput("mem_k3_cntB", cntB, 16'd5);
        checkOutput("mem_k3_cntC", 16'(cntC), 16'd1);
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k4_refreeze_ctlA", 16'(ctlA), 16'(CTL_OFF));
        applyStimulus(1, 1, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("mem_k5_wait_ctlA", 16'(ctlA), 16'(CTL_OFF));
        checkOutput("mem_k5_ctlB", 16'(ctlB), 16'(CTL_BRANCH));

        // Reset mid-WAIT: outputs drop at once, FSM and counters clear.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_ctlB", 16'(ctlB), 16'(CTL_OFF));
        checkOutput("rst_async_ctlA", 16'(ctlA), 16'(CTL_OFF));
        @(negedge clk);
        rst = 1'b0;
        branchTaken = 1'b0;
        memAccess = 1'b0;
        exMemRd = 1'b0;
        exWbEn = 1'b0;
        #1;
        checkOutput("rst_wait_run_ctlA", 16'(ctlA), 16'(CTL_NORMAL));
        checkOutput("rst_wait_cntA", cntA, 16'd0);

        // Saturation of the 2-bit counter under a sustained load-use stall.
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        checkOutput("sat_cntC_2", 16'(cntC), 16'd2);
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        applyStimulus(0, 0, 1, 1, 4'd5, 0, 4'd0, 1, 4'd5, 0, 4'd0);
        applyStimulus(0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0);
        checkOutput("sat_cntC_3", 16'(cntC), 16'd3);
        checkOutput("sat_cntA_5", cntA, 16'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
